pc_fetch_unit: RTL and testbench

//  Parametrised next-generation program counter with fetch front end for the RV32 core.

---
 rtl/rv_fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/pc_fetch_unit.sv | 131 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and defaults for the RV32 instruction fetch front end.
package rv_fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN     = 32;
  localparam logic [XLEN_DEF-1:0] RESET_VEC_DEF = '0;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN-1:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush; head is read straight from the array.
import rv_fetch_pkg::*;

module fetch_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     wdata,
  input  logic                       pop,
  output entry_t                     rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            wr_en;
  logic            rd_en;

  // Flush wins over both ports so nothing from the flushed stream survives.
  assign wr_en = push && !flush && !full;
  assign rd_en = pop && !flush && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wdata;
  end

  assign rdata = mem[rd_ptr_reg];
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch front end: issues imem requests under a credit limit, tracks
// outstanding fetches, drops stale responses after trap/redirect and buffers the rest.
import rv_fetch_pkg::*;

module pc_fetch_unit #(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int              DEPTH     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [ILEN-1:0] if_instr_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] cur_pc_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_next;
  logic [XLEN-1:0] resp_pc_q, resp_pc_next;
  logic [CW-1:0]   out_cnt_q, out_cnt_next;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_next;

  logic            flush;
  logic [XLEN-1:0] target;
  logic [CW:0]     inflight;
  logic            gnt_fire;
  logic            push;
  logic            pop;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_cnt;
  entry_t          push_entry;
  entry_t          head;

  assign flush  = trap_i || redirect_i;
  assign target = trap_i ? {trap_pc_i[XLEN-1:2], 2'b00} : {redirect_pc_i[XLEN-1:2], 2'b00};

  // Every slot is reserved at grant time, so in-flight plus buffered never exceeds DEPTH.
  assign inflight   = {1'b0, out_cnt_q} + {1'b0, q_cnt};
  assign imem_req_o = rst_n && !flush && !stall_i && (inflight < {1'b0, DEPTH_C});
  assign gnt_fire   = imem_req_o && imem_gnt_i;

  assign push       = imem_rvalid_i && (drop_cnt_q == '0) && !flush;
  assign pop        = if_valid_o && if_ready_i && !flush;
  assign push_entry = '{pc: resp_pc_q, instr: imem_rdata_i};

  always_comb begin
    pc_next       = pc_q;
    resp_pc_next  = resp_pc_q;
    out_cnt_next  = out_cnt_q;
    drop_cnt_next = drop_cnt_q;
    if (flush) begin
      // Everything still outstanding after this cycle belongs to the old stream.
      pc_next       = target;
      resp_pc_next  = target;
      out_cnt_next  = out_cnt_q - CW'(imem_rvalid_i);
      drop_cnt_next = out_cnt_q - CW'(imem_rvalid_i);
    end else begin
      if (gnt_fire) pc_next = pc_q + XLEN'(4);
      out_cnt_next = out_cnt_q + CW'(gnt_fire) - CW'(imem_rvalid_i);
      if (imem_rvalid_i) begin
        if (drop_cnt_q != '0) drop_cnt_next = drop_cnt_q - CW'(1);
        else                  resp_pc_next  = resp_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      resp_pc_q  <= RESET_VEC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_next;
      resp_pc_q  <= resp_pc_next;
      out_cnt_q  <= out_cnt_next;
      drop_cnt_q <= drop_cnt_next;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_cnt)
  );

  // Head storage is not reset, so the data outputs are masked while the queue is empty.
  assign if_valid_o  = !q_empty;
  assign if_pc_o     = q_empty ? '0 : head.pc;
  assign if_instr_o  = q_empty ? '0 : head.instr;
  assign imem_addr_o = pc_q;
  assign cur_pc_o    = pc_q;

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> (out_cnt_q != '0));
  a_cnt_order: assert property (@(posedge clk) disable iff (!rst_n)
    (drop_cnt_q <= out_cnt_q) && (out_cnt_q <= DEPTH_C));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && q_full && !pop));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand-written corner sequences, and a
// randomized run checked against an epoch-tagged transaction model.
module tb_pc_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RVEC  = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0, redirect_i = 1'b0, trap_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, trap_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o, if_instr_o;
  logic        if_ready_i = 1'b0;
  logic [31:0] cur_pc_o;

  always #5 clk = ~clk;

  pc_fetch_unit #(.XLEN(32), .RESET_VEC(RVEC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .trap_i(trap_i), .trap_pc_i(trap_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .if_valid_o(if_valid_o),
    .if_pc_o(if_pc_o), .if_instr_o(if_instr_o), .if_ready_i(if_ready_i), .cur_pc_o(cur_pc_o)
  );

  int n_total = 0;
  int n_pass  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic st, input logic rd, input logic tr, input logic gn,
                       input logic rv, input logic rdy, input logic [31:0] rpc,
                       input logic [31:0] tpc, input logic [31:0] rdat);
    @(negedge clk);
    stall_i = st; redirect_i = rd; trap_i = tr; imem_gnt_i = gn; imem_rvalid_i = rv;
    if_ready_i = rdy; redirect_pc_i = rpc; trap_pc_i = tpc; imem_rdata_i = rdat;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    stall_i = 0; redirect_i = 0; trap_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0;
    if_ready_i = 0; redirect_pc_i = '0; trap_pc_i = '0; imem_rdata_i = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, RVEC);
    chk("rst_valid", if_valid_o, 0);
    chk("rst_ifpc", if_pc_o, 0);
    chk("rst_instr", if_instr_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic st, rd, tr, gn, rv, rdy;
    logic [31:0] rpc, tpc, rdat;
    logic e_req; logic [31:0] e_addr;
    logic e_val; logic [31:0] e_pc, e_ins;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic rd, input logic tr, input logic gn,
                              input logic rv, input logic [31:0] raddr, input logic rdy,
                              input logic [31:0] rpc, input logic [31:0] tpc,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_val, input logic [31:0] e_pc);
    vec_t v;
    v.st = st; v.rd = rd; v.tr = tr; v.gn = gn; v.rv = rv; v.rdy = rdy;
    v.rpc = rpc; v.tpc = tpc; v.rdat = mem_word(raddr);
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc; v.e_ins = mem_word(e_pc);
    return v;
  endfunction

  typedef struct { logic [31:0] addr; int epoch; int cyc; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_total);
    $fatal(1);
  end

  initial begin
    vec_t  vecs [18];
    pend_t pend[$];
    ent_t  mq[$];
    pend_t p;
    logic [31:0] m_pc;
    int    epoch, cyc;
    logic  st, rd, tr, gn, rv, rdy, exp_req, flush;
    logic [31:0] rpc, tpc, rdat;

    // st rd tr gn rv raddr rdy rpc tpc | req addr valid if_pc
    vecs[0]  = mk(0,0,0,1,0,32'h00,1,0,0,             1,32'h000,0,32'h00);
    vecs[1]  = mk(0,0,0,1,1,32'h00,1,0,0,             1,32'h004,0,32'h00);
    vecs[2]  = mk(0,0,0,1,1,32'h04,1,0,0,             0,32'h008,1,32'h00);
    vecs[3]  = mk(0,0,0,1,0,32'h00,1,0,0,             1,32'h008,1,32'h04);
    vecs[4]  = mk(0,0,0,1,1,32'h08,1,0,0,             1,32'h00C,0,32'h00);
    vecs[5]  = mk(0,0,0,1,1,32'h0C,1,0,0,             0,32'h010,1,32'h08);
    vecs[6]  = mk(0,0,0,0,0,32'h00,1,0,0,             1,32'h010,1,32'h0C);
    vecs[7]  = mk(0,0,0,1,0,32'h00,0,0,0,             1,32'h010,0,32'h00);
    vecs[8]  = mk(0,0,0,1,0,32'h00,0,0,0,             1,32'h014,0,32'h00);
    vecs[9]  = mk(0,0,0,1,1,32'h10,0,0,0,             0,32'h018,0,32'h00);
    vecs[10] = mk(0,0,0,1,1,32'h14,0,0,0,             0,32'h018,1,32'h10);
    vecs[11] = mk(0,0,0,1,0,32'h00,0,0,0,             0,32'h018,1,32'h10);
    vecs[12] = mk(0,0,0,1,0,32'h00,1,0,0,             0,32'h018,1,32'h10);
    vecs[13] = mk(0,0,0,0,0,32'h00,0,0,0,             1,32'h018,1,32'h14);
    vecs[14] = mk(0,1,1,1,0,32'h00,1,32'h100,32'h200, 0,32'h018,1,32'h14);
    vecs[15] = mk(0,0,0,0,0,32'h00,0,0,0,             1,32'h200,0,32'h00);
    vecs[16] = mk(0,1,0,1,0,32'h00,0,32'h107,0,       0,32'h200,0,32'h00);
    vecs[17] = mk(0,0,0,0,0,32'h00,0,0,0,             1,32'h104,0,32'h00);

    // Directed table: in-order fetch, credit limit with decode blocked, trap over redirect.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].st, vecs[i].rd, vecs[i].tr, vecs[i].gn, vecs[i].rv, vecs[i].rdy,
            vecs[i].rpc, vecs[i].tpc, vecs[i].rdat);
      $display("vec %0d: req=%0b addr=%h valid=%0b if_pc=%h", i, imem_req_o, imem_addr_o,
               if_valid_o, if_pc_o);
      chk($sformatf("vec%0d_req", i), imem_req_o, vecs[i].e_req);
      chk($sformatf("vec%0d_addr", i), imem_addr_o, vecs[i].e_addr);
      chk($sformatf("vec%0d_curpc", i), cur_pc_o, vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), if_valid_o, vecs[i].e_val);
      if (vecs[i].e_val) begin
        chk($sformatf("vec%0d_ifpc", i), if_pc_o, vecs[i].e_pc);
        chk($sformatf("vec%0d_instr", i), if_instr_o, vecs[i].e_ins);
      end
    end

    // Redirect with two fetches in flight: both responses must be dropped.
    do_reset();
    drive(0,0,0,1,0,1,0,0,0);                 chk("rd_req0", imem_req_o, 1); chk("rd_addr0", imem_addr_o, 32'h0);
    drive(0,0,0,1,0,1,0,0,0);                 chk("rd_addr1", imem_addr_o, 32'h4);
    drive(0,1,0,0,0,1,32'h100,0,0);           chk("rd_req_redir", imem_req_o, 0);
    drive(0,0,0,0,1,1,0,0,mem_word(32'h0));   chk("rd_req_full", imem_req_o, 0); chk("rd_valid_a", if_valid_o, 0);
    drive(0,0,0,1,1,1,0,0,mem_word(32'h4));   chk("rd_req_new", imem_req_o, 1); chk("rd_addr_new", imem_addr_o, 32'h100);
    drive(0,0,0,1,1,1,0,0,mem_word(32'h100)); chk("rd_valid_b", if_valid_o, 0); chk("rd_addr104", imem_addr_o, 32'h104);
    drive(0,0,0,0,1,1,0,0,mem_word(32'h104)); chk("rd_ifpc100", if_pc_o, 32'h100); chk("rd_ins100", if_instr_o, mem_word(32'h100));
    drive(0,0,0,0,0,1,0,0,0);                 chk("rd_ifpc104", if_pc_o, 32'h104); chk("rd_ins104", if_instr_o, mem_word(32'h104));
    idle();                                   chk("rd_drained", if_valid_o, 0);
    $display("seq redirect: done");

    // Stall for five cycles with one fetch in flight.
    do_reset();
    drive(0,0,0,1,0,0,0,0,0);                 chk("st_req0", imem_req_o, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1,0,0,1,(i == 1),0,0,0,mem_word(32'h0));
      chk($sformatf("st_req_%0d", i), imem_req_o, 0);
      chk($sformatf("st_pc_%0d", i), cur_pc_o, 32'h4);
    end
    idle();
    chk("st_valid", if_valid_o, 1); chk("st_ifpc", if_pc_o, 32'h0);
    chk("st_ins", if_instr_o, mem_word(32'h0)); chk("st_req_after", imem_req_o, 1);
    $display("seq stall: done");

    // PC wrap at the top of the address space, then asynchronous reset mid-fetch.
    do_reset();
    drive(0,1,0,0,0,0,32'hFFFF_FFFC,0,0);     chk("wr_req_redir", imem_req_o, 0);
    drive(0,0,0,1,0,0,0,0,0);                 chk("wr_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    drive(0,0,0,1,1,0,0,0,mem_word(32'hFFFF_FFFC)); chk("wr_addr_wrap", imem_addr_o, 32'h0); chk("wr_req_wrap", imem_req_o, 1);
    idle();                                   chk("wr_ifpc", if_pc_o, 32'hFFFF_FFFC);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", if_valid_o, 0); chk("ar_req", imem_req_o, 0); chk("ar_pc", cur_pc_o, RVEC);
    chk("ar_ifpc", if_pc_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("ar_valid_post", if_valid_o, 0); chk("ar_addr_post", imem_addr_o, RVEC);
    chk("ar_req_post", imem_req_o, 1);
    $display("seq wrap/reset: done");

    // Randomized run against the transaction model.
    do_reset();
    m_pc = RVEC; epoch = 0; cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      tr  = ($urandom_range(0, 31) == 0);
      rd  = ($urandom_range(0, 11) == 0);
      st  = ($urandom_range(0, 4) == 0);
      rdy = $urandom_range(0, 1);
      gn  = ($urandom_range(0, 2) != 0);
      rv  = (pend.size() > 0) && (pend[0].cyc < cyc) && ($urandom_range(0, 2) != 0);
      rdat = rv ? mem_word(pend[0].addr) : $urandom;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      tpc = $urandom;
      drive(st, rd, tr, gn, rv, rdy, rpc, tpc, rdat);

      exp_req = !tr && !rd && !st && ((pend.size() + mq.size()) < DEPTH);
      chk("rnd_req", imem_req_o, exp_req);
      chk("rnd_addr", imem_addr_o, m_pc);
      chk("rnd_valid", if_valid_o, (mq.size() != 0));
      if (mq.size() != 0) begin
        chk("rnd_ifpc", if_pc_o, mq[0].pc);
        chk("rnd_instr", if_instr_o, mq[0].ins);
      end

      flush = tr || rd;
      if ((mq.size() != 0) && rdy && !flush) void'(mq.pop_front());
      if (rv) begin
        p = pend.pop_front();
        if ((p.epoch == epoch) && !flush) mq.push_back('{pc: p.addr, ins: mem_word(p.addr)});
      end
      if (exp_req && gn) begin
        pend.push_back('{addr: m_pc, epoch: epoch, cyc: cyc});
        m_pc = m_pc + 32'd4;
      end
      if (flush) begin
        mq.delete();
        epoch++;
        m_pc = (tr ? tpc : rpc) & ~32'h3;
      end
      cyc++;
    end
    $display("random run: %0d cycles", cyc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
